// File: rtl/f_stage_pc_if.sv
// Instruction-memory fetch bus between the fetch stage and the IM.
// The fetch stage is the master: it drives the address and consumes the word.
interface f_stage_pc_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;

    modport master (
        output i_inst_addr,
        input  i_inst_rdata
    );

    modport slave (
        input  i_inst_addr,
        output i_inst_rdata
    );
endinterface

// File: rtl/f_stage_pc.sv
// Fetch stage of the P7 MIPS pipeline.
// Owns the architectural fetch PC, picks the next PC from the sequential,
// branch, jump, register-jump, ERET and exception-entry sources, drives the
// IM address, flags fetch address errors (AdEL) and the delay-slot bit.
module f_stage_pc #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_TOP    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic [1:0]  D_npc_sel,
    input  logic [31:0] D_br_target,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_fwd,
    input  logic        D_is_bj,
    f_stage_pc_if.master im,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic [4:0]  F_EXCCode,
    output logic        F_delayed
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_seq;
    logic [31:0] fetch_pc;
    logic        adel;

    // ERET has no delay slot, so the instruction at EPC is fetched while ERET is still in D.
    always_comb begin
        fetch_pc = D_eret ? EPC : pc_q;
    end

    // Fetch address error: misaligned word or outside the instruction memory window.
    always_comb begin
        adel = (fetch_pc[1:0] != 2'b00) || (fetch_pc < IM_BASE) || (fetch_pc > IM_TOP);
    end

    // Drive the IM bus and the F/D register inputs; a faulting fetch is squashed to a nop.
    always_comb begin
        im.i_inst_addr = fetch_pc;
        F_pc           = fetch_pc;
        F_instr        = adel ? 32'h0000_0000 : im.i_inst_rdata;
        F_EXCCode      = adel ? EXC_ADEL : 5'd0;
        F_delayed      = D_is_bj & ~D_eret;
    end

    // Next-PC selection: exception entry beats a stall, a stall beats every redirect.
    always_comb begin
        pc_seq  = pc_q + 32'd4;
        pc_next = pc_seq;
        if (Req) begin
            pc_next = EXC_ENTRY;
        end else if (!enable) begin
            pc_next = pc_q;
        end else if (D_eret) begin
            pc_next = EPC + 32'd4;
        end else begin
            case (D_npc_sel)
                2'b01:   pc_next = D_br_target;
                2'b10:   pc_next = {pc_q[31:28], D_imm26, 2'b00};
                2'b11:   pc_next = D_rs_fwd;
                default: pc_next = pc_seq;
            endcase
        end
    end

    // Architectural fetch PC register; reset discards any redirect pending in D.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: tb/tb_f_stage_pc.sv
// Self-checking bench for the fetch stage: a table of per-cycle stimulus with
// hand-derived expected outputs, routed through a scoreboard queue.
module tb_f_stage_pc;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        Req;
    logic        D_eret;
    logic [31:0] EPC;
    logic [1:0]  D_npc_sel;
    logic [31:0] D_br_target;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_fwd;
    logic        D_is_bj;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic [4:0]  F_EXCCode;
    logic        F_delayed;

    int total = 0;
    int bad   = 0;

    f_stage_pc_if im ();

    f_stage_pc dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .Req         (Req),
        .D_eret      (D_eret),
        .EPC         (EPC),
        .D_npc_sel   (D_npc_sel),
        .D_br_target (D_br_target),
        .D_imm26     (D_imm26),
        .D_rs_fwd    (D_rs_fwd),
        .D_is_bj     (D_is_bj),
        .im          (im),
        .F_pc        (F_pc),
        .F_instr     (F_instr),
        .F_EXCCode   (F_EXCCode),
        .F_delayed   (F_delayed)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic        req;
        logic        eret;
        logic [31:0] epc;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [25:0] imm;
        logic [31:0] rs;
        logic        bj;
        logic        chk;
        logic [31:0] exp_pc;
        logic        exp_adel;
        logic        exp_del;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        del;
    } exp_t;

    vec_t tbl[$];
    vec_t hand[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic req, input logic eret,
                                input logic [31:0] epc, input logic [1:0] sel, input logic [31:0] br,
                                input logic [25:0] imm, input logic [31:0] rs, input logic bj,
                                input logic chk, input logic [31:0] exp_pc, input logic exp_adel,
                                input logic exp_del);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.eret = eret; v.epc = epc; v.sel = sel;
        v.br = br; v.imm = imm; v.rs = rs; v.bj = bj; v.chk = chk;
        v.exp_pc = exp_pc; v.exp_adel = exp_adel; v.exp_del = exp_del;
        return v;
    endfunction

    function automatic vec_t nrm(input logic [31:0] exp_pc, input logic exp_adel);
        return mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, exp_pc, exp_adel, 0);
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        logic [31:0] word;
        word        = 32'hC0DE_0000 + 32'(idx);
        reset       = v.rst;
        enable      = v.en;
        Req         = v.req;
        D_eret      = v.eret;
        EPC         = v.epc;
        D_npc_sel   = v.sel;
        D_br_target = v.br;
        D_imm26     = v.imm;
        D_rs_fwd    = v.rs;
        D_is_bj     = v.bj;
        im.i_inst_rdata = word;
        if (v.chk) begin
            e.idx   = idx;
            e.pc    = v.exp_pc;
            e.instr = v.exp_adel ? 32'h0 : word;
            e.exc   = v.exp_adel ? 5'd4 : 5'd0;
            e.del   = v.exp_del;
            sb.push_back(e);
        end
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        cmp("F_pc",        e.idx, F_pc,            e.pc);
        cmp("i_inst_addr", e.idx, im.i_inst_addr,  e.pc);
        cmp("F_instr",     e.idx, F_instr,         e.instr);
        cmp("F_EXCCode",   e.idx, 32'(F_EXCCode),  32'(e.exc));
        cmp("F_delayed",   e.idx, 32'(F_delayed),  32'(e.del));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; Req = 1'b0; D_eret = 1'b0; EPC = '0;
        D_npc_sel = 2'b00; D_br_target = '0; D_imm26 = '0; D_rs_fwd = '0; D_is_bj = 1'b0;
        im.i_inst_rdata = '0;

        // reset for two cycles, then sequential fetch
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        tbl.push_back(nrm(32'h3000, 0));
        tbl.push_back(nrm(32'h3004, 0));
        tbl.push_back(nrm(32'h3008, 0));
        tbl.push_back(nrm(32'h300C, 0));
        // branch at 0x3010 -> 0x3100
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 32'h3100, 0, 0, 1, 1, 32'h3010, 0, 1));
        tbl.push_back(nrm(32'h3100, 0));
        // j at delay-slot pc 0x3104 -> 0x3020
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b10, 0, 26'h0000C08, 0, 1, 1, 32'h3104, 0, 1));
        // stall two cycles (branch request ignored), then Req during stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b01, 32'h5000, 0, 0, 0, 1, 32'h3020, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h3020, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h3020, 0, 0));
        tbl.push_back(nrm(32'h4180, 0));
        tbl.push_back(nrm(32'h4184, 0));
        tbl.push_back(nrm(32'h4188, 0));
        tbl.push_back(nrm(32'h418C, 0));
        // ERET at pc 0x4190 with EPC 0x3040
        tbl.push_back(mk(0, 1, 0, 1, 32'h3040, 2'b00, 0, 0, 0, 1, 1, 32'h3040, 0, 0));
        // jr to misaligned 0x3002
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'h3002, 1, 1, 32'h3044, 0, 1));
        // fault fetch, jr to 0x7000
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'h7000, 0, 1, 32'h3002, 1, 0));
        // out-of-range fetch, then Req
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h7000, 1, 0));
        // Req together with ERET: Req wins the next PC
        tbl.push_back(mk(0, 1, 1, 1, 32'h3200, 2'b00, 0, 0, 0, 0, 1, 32'h3200, 0, 0));
        // jr to IM_TOP
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'h6FFC, 0, 1, 32'h4180, 0, 0));
        tbl.push_back(nrm(32'h6FFC, 0));
        // just above IM_TOP, jr just below IM_BASE
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'h2FFC, 0, 1, 32'h7000, 1, 0));
        // ERET during stall: fetch at EPC, pc holds, branch ignored
        tbl.push_back(mk(0, 0, 0, 1, 32'h3300, 2'b01, 32'h3500, 0, 0, 1, 1, 32'h3300, 0, 0));
        // jr to high region
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'h9000_0010, 0, 1, 32'h2FFC, 1, 0));
        // j keeps pc[31:28]
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b10, 0, 26'h0000C10, 0, 1, 1, 32'h9000_0010, 1, 1));
        // reset with a pending branch
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 32'h3500, 0, 0, 1, 1, 32'h9000_3040, 1, 1));
        // wrap-around of pc+4
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 32'hFFFF_FFFC, 0, 1, 32'h3000, 0, 0));
        tbl.push_back(nrm(32'hFFFF_FFFC, 1));
        tbl.push_back(nrm(32'h0000_0000, 1));

        // reset beats Req, stall after reset, ERET beats a branch select
        hand.push_back(mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0));
        hand.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h3000, 0, 0));
        hand.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 26'h3FF_FFFF, 0, 0, 1, 32'h3000, 0, 0));
        hand.push_back(mk(0, 1, 0, 1, 32'h3400, 2'b01, 32'h3500, 0, 0, 0, 1, 32'h3400, 0, 0));
        hand.push_back(nrm(32'h3404, 0));

        $display("[TB] table vectors: %0d", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            applyStimulus(tbl[i], i);
            #1;
            checkOutput();
        end

        $display("[TB] hand sequence");
        for (int i = 0; i < hand.size(); i++) begin
            @(negedge clk);
            applyStimulus(hand[i], 100 + i);
            #1;
            checkOutput();
        end

        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f_stage_pc.md
Name: f_stage_pc

Overview:
- Fetch stage of the P7 MIPS pipeline; feeds the F/D pipeline register with F_pc, F_instr, F_EXCCode and F_delayed.
- Holds the architectural fetch PC and selects the next PC from sequential, branch, jump, register-jump, ERET and exception-entry sources.
- Drives the instruction-memory address and detects fetch address errors (AdEL).
- Generates the branch-delay-slot flag used by CP0 to compute EPC and the BD bit.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, handler entry PC loaded on Req.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6ffc, highest legal fetch address (inclusive).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  PC update enable; 0 = stall, hold PC.
- Req  input  1  exception/interrupt request from CP0; forces PC to EXC_ENTRY.
- D_eret  input  1  ERET is in D this cycle.
- EPC  input  32  CP0 EPC value.
- D_npc_sel  input  2  00 = pc+4, 01 = branch, 10 = j/jal, 11 = jr/jalr.
- D_br_target  input  32  branch target, already computed in D.
- D_imm26  input  26  jump index field.
- D_rs_fwd  input  32  forwarded rs value for jr/jalr.
- D_is_bj  input  1  the instruction in D is a branch or jump.
- i_inst_rdata  input  32  instruction word from IM.
- i_inst_addr  output  32  fetch address to IM.
- F_pc  output  32  PC of the fetched instruction.
- F_instr  output  32  fetched instruction, or 0 on AdEL.
- F_EXCCode  output  5  0, or 5'd4 on AdEL.
- F_delayed  output  1  fetched instruction is in a delay slot.

Behaviour:
- PC register: pc_q. Reset value is PC_RESET, applied on clk edge when reset=1.
- Effective fetch PC, combinational:
  - F_pc = D_eret ? EPC : pc_q.
  - i_inst_addr = F_pc.
  - ERET has no delay slot; the instruction at EPC is fetched in the same cycle ERET sits in D.
- Next-PC priority at posedge, highest first:
  1. reset: pc_q <= PC_RESET.
  2. Req: pc_q <= EXC_ENTRY. Applies regardless of enable.
  3. !enable: pc_q holds.
  4. D_eret: pc_q <= EPC+4.
  5. D_npc_sel=01: pc_q <= D_br_target.
  6. D_npc_sel=10: pc_q <= {pc_q[31:28], D_imm26, 2'b00}. pc_q is the delay-slot PC, i.e. D_pc+4.
  7. D_npc_sel=11: pc_q <= D_rs_fwd.
  8. Otherwise: pc_q <= pc_q+4.
- Arithmetic: 32-bit adds wrap modulo 2^32; no overflow detection.
- AdEL is set when F_pc[1:0]!=0, or F_pc<IM_BASE, or F_pc>IM_TOP (unsigned compare).
  - On AdEL: F_instr=0 and F_EXCCode=5'd4.
  - Otherwise: F_instr=i_inst_rdata and F_EXCCode=0.
- A misaligned or out-of-range jr target is not trapped here. It loads into pc_q, and AdEL is flagged on the following fetch.
- F_delayed = D_is_bj & ~D_eret. This is a combinational output; the D_eret term keeps it 0 while ERET occupies D.
- Stall (enable=0):
  - pc_q holds.
  - Outputs stay consistent with the held pc_q; the caller holds F/D.
  - D_npc_sel is ignored.
- Req and stall in the same cycle: Req wins, and pc_q <= EXC_ENTRY on that edge.
- Req and D_eret in the same cycle: Req wins.
- Reset mid-operation: discards any pending redirect; the first post-reset fetch is at PC_RESET.
- The block holds no other state; all outputs apart from pc_q are combinational from pc_q and its inputs.

Test Plan:
- Reset sequence: assert reset 2 cycles, then run 3 cycles with npc_sel=00 and enable=1 -> F_pc = 0x3000, 0x3004, 0x3008. F_EXCCode=0 and F_delayed=0 throughout.
- Branch and delay slot: pc_q=0x3010, D_is_bj=1, D_npc_sel=01, D_br_target=0x3100 -> F_delayed=1 this cycle, and the next-cycle F_pc=0x3100.
- Stall versus Req: enable=0 for 2 cycles at pc_q=0x3020 -> F_pc holds at 0x3020. Then Req=1 with enable=0 -> next F_pc=0x4180.
- ERET: D_eret=1, EPC=0x3040, pc_q=0x4190 -> F_pc=i_inst_addr=0x3040 and F_delayed=0 in the same cycle. The next-cycle F_pc=0x3044.
- AdEL via jr: D_npc_sel=11, D_rs_fwd=0x3002 -> next cycle F_pc=0x3002, F_EXCCode=4, F_instr=0.
- AdEL via range: jr to 0x7000 -> next cycle F_EXCCode=4. A following Req gives F_pc=0x4180 with F_EXCCode=0.
